fifo_read_packer: RTL and testbench
===================================

Name: fifo_read_packer

Overview:
- Sits in the clk_b domain directly downstream of the asynchronous FIFO, on its read side.
- Issues ren_b whenever the FIFO is non-empty and there is room to accept data.
- Packs PACK_RATIO consecutive FIFO_WIDTH-bit words LSB-first into one wide word.
- Presents the packed word on a valid/ready output with backpressure; a flush input forces out a partial word.

Parameters:
- FIFO_WIDTH, 4, width of each FIFO read word (nibble).
- PACK_RATIO, 4, FIFO words per output word; legal range 2..8.
- OUT_WIDTH, FIFO_WIDTH*PACK_RATIO, output word width; derived, must not be overridden.
- CNT_W, $clog2(PACK_RATIO+1), width of the fill counters.

Ports:
- clk_b  in  1  read-domain clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- empty  in  1  FIFO empty flag.
- ren_b  out  1  FIFO read enable.
- dout_b  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read.
- flush  in  1  level request to emit any partial word.
- out_data  out  OUT_WIDTH  packed word; slot 0 is in bits [FIFO_WIDTH-1:0].
- out_count  out  CNT_W  number of valid slots in out_data (1..PACK_RATIO).
- out_valid  out  1  out_data/out_count valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- words_out  out  16  count of words accepted by the consumer; wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=1 at a rising edge) clears the following to 0:
  - accumulator, acc_cnt, rd_pend;
  - out_data, out_count, out_valid, words_out.
  - ren_b is forced to 0 combinationally while rst=1.
  - An in-flight FIFO read is discarded: the dout_b arriving the cycle after reset is ignored.
- Read latency is one cycle. ren_b=1 at edge N means dout_b is captured at edge N+1; rd_pend=1 marks that in-flight read.
- Transfer condition: xfer = (acc_cnt==PACK_RATIO) && (!out_valid || out_ready).
- Flush-transfer condition: fxfer = flush && rd_pend==0 && 0<acc_cnt<PACK_RATIO && (!out_valid || out_ready).
- ren_b (combinational) = !rst && !empty && !flush && ((acc_cnt + rd_pend < PACK_RATIO) || xfer).
- Capture: when rd_pend=1, dout_b is written into slot acc_cnt' and acc_cnt' increments.
  - acc_cnt' is 0 if xfer happens in the same cycle, else acc_cnt.
- Each accumulator slot is written exactly once per word. Slots that are not filled read as 0 when transferred.
- xfer/fxfer on the same edge:
  - out_data <= accumulator (unfilled slots zeroed), out_count <= acc_cnt, out_valid <= 1;
  - accumulator cleared.
- out_valid clears on acceptance unless a new xfer or fxfer loads the register on the same edge.
- out_data and out_count hold stable while out_valid && !out_ready.
- words_out increments on every accepted word.
- States (encoded by acc_cnt / rd_pend / out_valid):
  - FILL: acc_cnt<PACK_RATIO.
  - FULL_WAIT: acc_cnt==PACK_RATIO and output blocked; ren_b=0.
  - FLUSH_DRAIN: flush=1; ren_b=0; waits for rd_pend to clear, then performs fxfer.
- Throughput with empty=0 and out_ready=1: PACK_RATIO reads per PACK_RATIO+1 cycles, i.e. one bubble per word, at the cycle where acc_cnt+rd_pend==PACK_RATIO.
- Flush details:
  - Flush with acc_cnt==0 and rd_pend==0 does nothing.
  - Flush with acc_cnt==PACK_RATIO behaves as a normal xfer.
  - Flush held high after emitting a word emits nothing further until new data arrives, which cannot happen while flush=1.
- empty rising while rd_pend=1: the pending data is still captured; no further reads are issued.
- The block never reads when empty=1, and never loses a word under any out_ready pattern.

Test Plan:
- After reset, FIFO model preloaded with nibbles 1..8, out_ready=1 -> out_data 0x4321 then 0x8765, out_count=4 for both, words_out=2, ren_b high for exactly 8 cycles.
- Same data with out_ready=0 for 20 cycles, then 1 -> out_data stays 0x4321 while stalled; ren_b deasserts after nibble 8 is accumulated (acc_cnt==4, FULL_WAIT); then 0x8765 follows; no duplicates or loss.
- FIFO holds A,B,C then empty=1; flush pulsed 3 cycles -> single word 0x0CBA, out_count=3; no read issued while flush=1.
- rst asserted on the cycle after ren_b=1 with acc_cnt=2 -> all outputs 0 next cycle; in-flight nibble dropped; next word starts clean in slot 0.
- empty=1 continuously, out_ready random for 100 cycles -> ren_b never 1, out_valid never 1.
- 1000 random nibbles, random out_ready at 50% -> scoreboard matches every packed word; words_out=250; sustained rate with out_ready=1 is 4 nibbles per 5 cycles.

Source files
------------

// File: rtl/fifo_read_packer.sv
// fifo_read_packer
// Read-side companion of the asynchronous FIFO in the clk_b domain. It pulls
// FIFO_WIDTH-bit words whenever the FIFO has data and there is room, packs
// PACK_RATIO of them LSB-first into one OUT_WIDTH-bit word, and offers that
// word on a valid/ready interface. A level-sensitive flush pushes out a
// partially filled word once any in-flight read has landed.
//
// The operating phases are fully described by acc_cnt, rd_pend and out_valid:
//   FILL        : acc_cnt < PACK_RATIO, reads issued while slots remain
//   FULL_WAIT   : acc_cnt == PACK_RATIO with the output register occupied
//   FLUSH_DRAIN : flush high, reads suppressed, partial word sent once
//                 rd_pend has cleared
// so no separate state register is kept.

module fifo_read_packer #(
    parameter int FIFO_WIDTH = 4,
    parameter int PACK_RATIO = 4,
    parameter int OUT_WIDTH  = FIFO_WIDTH * PACK_RATIO,
    parameter int CNT_W      = $clog2(PACK_RATIO + 1)
) (
    input  logic                  clk_b,
    input  logic                  rst,
    input  logic                  empty,
    output logic                  ren_b,
    input  logic [FIFO_WIDTH-1:0] dout_b,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           words_out
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]     acc_cnt;
    logic [CNT_W-1:0]     acc_cnt_next;
    logic [CNT_W-1:0]     base_cnt;
    logic                 rd_pend;
    logic                 out_free;
    logic                 xfer;
    logic                 fxfer;
    logic                 load;
    logic [CNT_W:0]       committed;

    // Transfer decisions and the FIFO read request; the read is allowed when
    // the slots already filled plus the read in flight leave room, or when a
    // full word leaves the accumulator on this same edge.
    always_comb begin
        out_free  = !out_valid || out_ready;
        xfer      = (acc_cnt == FULL_CNT) && out_free;
        fxfer     = flush && !rd_pend && (acc_cnt != '0) &&
                    (acc_cnt < FULL_CNT) && out_free;
        load      = xfer || fxfer;
        committed = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, rd_pend};
        ren_b     = !rst && !empty && !flush &&
                    ((committed < {1'b0, FULL_CNT}) || xfer);
    end

    // Next accumulator contents: clear on an outgoing word, then drop the
    // arriving FIFO word into the first free slot (slot 0 after a transfer).
    always_comb begin
        base_cnt     = load ? '0 : acc_cnt;
        acc_next     = load ? '0 : acc;
        acc_cnt_next = base_cnt;
        if (rd_pend) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (base_cnt == CNT_W'(i)) begin
                    acc_next[i*FIFO_WIDTH +: FIFO_WIDTH] = dout_b;
                end
            end
            acc_cnt_next = base_cnt + CNT_W'(1);
        end
    end

    // Accumulator, read tracking, output register and accepted-word counter.
    always_ff @(posedge clk_b) begin
        if (rst) begin
            acc       <= '0;
            acc_cnt   <= '0;
            rd_pend   <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            words_out <= 16'd0;
        end else begin
            acc     <= acc_next;
            acc_cnt <= acc_cnt_next;
            rd_pend <= ren_b;
            if (load) begin
                out_data  <= acc;
                out_count <= acc_cnt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                words_out <= words_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer
// Drives fifo_read_packer from a queue-based FIFO model and checks the packed
// words against nibble streams grouped four at a time.

module tb_fifo_read_packer;

    localparam int FW = 4;
    localparam int PR = 4;
    localparam int OW = FW * PR;
    localparam int CW = 3;

    logic          clk_b = 1'b0;
    logic          rst;
    logic          empty;
    logic          ren_b;
    logic [FW-1:0] dout_b;
    logic          flush;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   words_out;

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] fifo_q[$];
    logic [OW-1:0] got_data[$];
    logic [CW-1:0] got_cnt[$];
    int            ren_cycles;
    int            valid_seen;
    bit            prev_hold;
    logic [OW-1:0] prev_data;
    logic [CW-1:0] prev_cnt;

    fifo_read_packer #(
        .FIFO_WIDTH (FW),
        .PACK_RATIO (PR)
    ) dut (
        .clk_b     (clk_b),
        .rst       (rst),
        .empty     (empty),
        .ren_b     (ren_b),
        .dout_b    (dout_b),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .words_out (words_out)
    );

    // Free-running read-domain clock.
    always #5 clk_b = ~clk_b;

    // One clock cycle: update empty, sample before the edge, then deliver the
    // FIFO word one cycle after an accepted read.
    task automatic tick();
        logic ren_s;
        @(negedge clk_b);
        empty = (fifo_q.size() == 0);
        #1;
        ren_s = ren_b;
        if (ren_s) ren_cycles++;
        if (out_valid) valid_seen++;
        checks++;
        if (ren_s && empty) begin
            failures++;
            $display("[TB] FAIL read_while_empty: ren_b=%b with empty=%b, required ren_b=0", ren_s, empty);
        end
        if (rst) begin
            checks++;
            if (ren_s !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ren_in_reset: ren_b=%b, required 0", ren_s);
            end
        end
        if (prev_hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_count !== prev_cnt) begin
                failures++;
                $display("[TB] FAIL stall_hold: got v=%b %h/%0d, required v=1 %h/%0d",
                         out_valid, out_data, out_count, prev_data, prev_cnt);
            end
        end
        prev_hold = out_valid && !out_ready && !rst;
        prev_data = out_data;
        prev_cnt  = out_count;
        if (out_valid && out_ready && !rst) begin
            got_data.push_back(out_data);
            got_cnt.push_back(out_count);
        end
        @(posedge clk_b);
        #1;
        if (ren_s && fifo_q.size() > 0) dout_b = fifo_q.pop_front();
        else                            dout_b = 4'($urandom);
    endtask

    task automatic do_reset();
        prev_hold = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_q.delete();
        tick();
        tick();
        rst = 1'b0;
        got_data.delete();
        got_cnt.delete();
        ren_cycles = 0;
        valid_seen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || words_out !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: v=%b d=%h c=%0d w=%0d, required all 0",
                     out_valid, out_data, out_count, words_out);
        end
        rst = 1'b1;
        fifo_q.push_back(4'h5);
        empty = 1'b0;
        #1;
        checks++;
        if (ren_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ren_forced: ren_b=%b, required 0", ren_b);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ren_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ren_after_reset: ren_b=%b, required 1", ren_b);
        end
        fifo_q.delete();
        empty = 1'b1;
    endtask

    task automatic test_basic();
        logic [OW-1:0] exp_d[2];
        exp_d[0] = 16'h4321;
        exp_d[1] = 16'h8765;
        do_reset();
        for (int n = 1; n <= 8; n++) fifo_q.push_back(4'(n));
        out_ready = 1'b1;
        repeat (25) tick();
        checks++;
        if (got_data.size() !== 2) begin
            failures++;
            $display("[TB] FAIL basic_words: got %0d words, required 2", got_data.size());
        end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_d[i] || got_cnt[i] !== 3'd4) begin
                failures++;
                $display("[TB] FAIL basic_word[%0d]: got %h/%0d, required %h/4", i, got_data[i], got_cnt[i], exp_d[i]);
            end
        end
        checks++;
        if (words_out !== 16'd2) begin
            failures++;
            $display("[TB] FAIL basic_words_out: got %0d, required 2", words_out);
        end
        checks++;
        if (ren_cycles !== 8) begin
            failures++;
            $display("[TB] FAIL basic_ren_cycles: got %0d, required 8", ren_cycles);
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp_d[3];
        exp_d[0] = 16'h4321;
        exp_d[1] = 16'h8765;
        exp_d[2] = 16'hCBA9;
        do_reset();
        for (int n = 1; n <= 12; n++) fifo_q.push_back(4'(n));
        out_ready = 1'b0;
        repeat (20) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
            failures++;
            $display("[TB] FAIL stall_word: v=%b d=%h, required v=1 d=4321", out_valid, out_data);
        end
        checks++;
        if (ren_cycles !== 8 || fifo_q.size() !== 4) begin
            failures++;
            $display("[TB] FAIL stall_reads: reads=%0d left=%0d, required reads=8 left=4", ren_cycles, fifo_q.size());
        end
        checks++;
        if (ren_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_wait_ren: ren_b=%b, required 0", ren_b);
        end
        out_ready = 1'b1;
        repeat (30) tick();
        checks++;
        if (got_data.size() !== 3) begin
            failures++;
            $display("[TB] FAIL stall_words: got %0d words, required 3", got_data.size());
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_d[i] || got_cnt[i] !== 3'd4) begin
                failures++;
                $display("[TB] FAIL stall_word[%0d]: got %h/%0d, required %h/4", i, got_data[i], got_cnt[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        fifo_q.push_back(4'hA);
        fifo_q.push_back(4'hB);
        fifo_q.push_back(4'hC);
        out_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (got_data.size() !== 0) begin
            failures++;
            $display("[TB] FAIL partial_no_flush: got %0d words, required 0", got_data.size());
        end
        fifo_q.push_back(4'hD);
        ren_cycles = 0;
        flush      = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        checks++;
        if (ren_cycles !== 0 || fifo_q.size() !== 1) begin
            failures++;
            $display("[TB] FAIL flush_no_read: reads=%0d left=%0d, required reads=0 left=1", ren_cycles, fifo_q.size());
        end
        checks++;
        if (got_data.size() !== 1) begin
            failures++;
            $display("[TB] FAIL flush_words: got %0d words, required 1", got_data.size());
        end else if (got_data[0] !== 16'h0CBA || got_cnt[0] !== 3'd3) begin
            failures++;
            $display("[TB] FAIL flush_word: got %h/%0d, required 0cba/3", got_data[0], got_cnt[0]);
        end
        repeat (4) tick();
        flush = 1'b1;
        repeat (6) tick();
        flush = 1'b0;
        checks++;
        if (got_data.size() !== 2) begin
            failures++;
            $display("[TB] FAIL flush_single: got %0d words, required 2", got_data.size());
        end else if (got_data[1] !== 16'h000D || got_cnt[1] !== 3'd1) begin
            failures++;
            $display("[TB] FAIL flush_one_slot: got %h/%0d, required 000d/1", got_data[1], got_cnt[1]);
        end
        checks++;
        if (words_out !== 16'd2) begin
            failures++;
            $display("[TB] FAIL flush_words_out: got %0d, required 2", words_out);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        fifo_q.push_back(4'h1);
        fifo_q.push_back(4'h2);
        fifo_q.push_back(4'h3);
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || words_out !== 16'd0) begin
            failures++;
            $display("[TB] FAIL inflight_reset: v=%b d=%h c=%0d w=%0d, required all 0",
                     out_valid, out_data, out_count, words_out);
        end
        fifo_q.push_back(4'h9);
        fifo_q.push_back(4'hA);
        fifo_q.push_back(4'hB);
        fifo_q.push_back(4'hC);
        repeat (15) tick();
        checks++;
        if (got_data.size() !== 1) begin
            failures++;
            $display("[TB] FAIL inflight_words: got %0d words, required 1", got_data.size());
        end else if (got_data[0] !== 16'hCBA9 || got_cnt[0] !== 3'd4) begin
            failures++;
            $display("[TB] FAIL inflight_clean: got %h/%0d, required cba9/4", got_data[0], got_cnt[0]);
        end
    endtask

    task automatic test_empty_idle();
        do_reset();
        repeat (100) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if (ren_cycles !== 0 || valid_seen !== 0) begin
            failures++;
            $display("[TB] FAIL idle: reads=%0d valid_cycles=%0d, required 0 and 0", ren_cycles, valid_seen);
        end
    endtask

    task automatic test_random();
        logic [FW-1:0] ref_n[$];
        logic [OW-1:0] exp_w;
        int            fed;
        int            burst;
        int            cyc;
        do_reset();
        for (int n = 0; n < 1000; n++) ref_n.push_back(4'($urandom));
        fed = 0;
        cyc = 0;
        while (cyc < 20000 && got_data.size() < 250) begin
            if (fed < 1000 && $urandom_range(0, 3) != 0) begin
                burst = int'($urandom_range(1, 6));
                for (int b = 0; b < burst && fed < 1000; b++) begin
                    fifo_q.push_back(ref_n[fed]);
                    fed++;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got_data.size() !== 250) begin
            failures++;
            $display("[TB] FAIL rand_words: got %0d words in %0d cycles, required 250", got_data.size(), cyc);
        end
        for (int i = 0; i < 250 && i < got_data.size(); i++) begin
            exp_w = '0;
            for (int k = 0; k < PR; k++) exp_w = exp_w | (OW'(ref_n[PR*i+k]) << (FW*k));
            checks++;
            if (got_data[i] !== exp_w || got_cnt[i] !== 3'd4) begin
                failures++;
                $display("[TB] FAIL rand_word[%0d]: got %h/%0d, required %h/4", i, got_data[i], got_cnt[i], exp_w);
            end
        end
        checks++;
        if (words_out !== 16'd250) begin
            failures++;
            $display("[TB] FAIL rand_words_out: got %0d, required 250", words_out);
        end
        checks++;
        if (ren_cycles !== 1000) begin
            failures++;
            $display("[TB] FAIL rand_reads: got %0d, required 1000", ren_cycles);
        end
    endtask

    task automatic test_rate();
        logic [FW-1:0] ref_n[$];
        logic [OW-1:0] exp_w;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            ref_n.push_back(4'($urandom));
            fifo_q.push_back(ref_n[n]);
        end
        out_ready = 1'b1;
        repeat (10) tick();
        ren_cycles = 0;
        repeat (50) tick();
        checks++;
        if (ren_cycles !== 40) begin
            failures++;
            $display("[TB] FAIL rate: got %0d reads in 50 cycles, required 40", ren_cycles);
        end
        repeat (150) tick();
        checks++;
        if (got_data.size() !== 30) begin
            failures++;
            $display("[TB] FAIL rate_words: got %0d words, required 30", got_data.size());
        end
        for (int i = 0; i < 30 && i < got_data.size(); i++) begin
            exp_w = '0;
            for (int k = 0; k < PR; k++) exp_w = exp_w | (OW'(ref_n[PR*i+k]) << (FW*k));
            checks++;
            if (got_data[i] !== exp_w) begin
                failures++;
                $display("[TB] FAIL rate_word[%0d]: got %h, required %h", i, got_data[i], exp_w);
            end
        end
    endtask

    // Scenario sequence and final summary.
    initial begin
        rst        = 1'b1;
        empty      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        dout_b     = '0;
        ren_cycles = 0;
        valid_seen = 0;
        prev_hold  = 1'b0;
        prev_data  = '0;
        prev_cnt   = '0;
        $display("[TB] starting fifo_read_packer bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_inflight();
        test_empty_idle();
        test_random();
        test_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
